// File: rtl/mc_controller.sv
// Multicycle ARM control unit: a Moore FSM sequences the shared datapath,
// with registered NZCV flags and per-instruction condition gating of all writes.
module mc_controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ALUControl,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic         RegWrite,
    output logic [1:0]   RegSrc,
    output logic [3:0]   State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t      state;
    logic [3:0]  flags;
    logic        condexq;
    logic        condex;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [1:0]  flagw;
    logic        next_pc, reg_w, mem_w, branch, alu_op, ir_w, pcs;
    logic        unused_rn;

    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign unused_rn = ^Instr[19:16];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            flags   <= 4'b0000;
            condexq <= 1'b0;
        end else begin
            case (state)
                FETCH:    state <= DECODE;
                DECODE: begin
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECUTEI : EXECUTER;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR:   state <= funct[0] ? MEMRD : MEMWR;
                MEMRD:    state <= MEMWB;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                default:  state <= FETCH;
            endcase
            // The condition verdict is frozen at DECODE so the instruction's own
            // flag update cannot alter its later write gating.
            if (state == DECODE)
                condexq <= condex;
            if (flagw[1] && condexq)
                flags[3:2] <= ALUFlags[3:2];
            if (flagw[0] && condexq)
                flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        ir_w      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        case (state)
            FETCH: begin
                ir_w = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
                ResultSrc = 2'b10; next_pc = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMRD:    AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01; reg_w = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1; mem_w = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01; alu_op = 1'b1;
            end
            ALUWB:    reg_w = 1'b1;
            BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        flagw      = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: ALUControl = 2'b00;
            endcase
            flagw[1] = funct[0];
            flagw[0] = funct[0] && (ALUControl == 2'b00 || ALUControl == 2'b01);
        end
    end

    // flags is {N,Z,C,V}
    always_comb begin
        condex = 1'b0;
        case (Instr[31:28])
            4'b0000: condex = flags[2];
            4'b0001: condex = !flags[2];
            4'b0010: condex = flags[1];
            4'b0011: condex = !flags[1];
            4'b0100: condex = flags[3];
            4'b0101: condex = !flags[3];
            4'b0110: condex = flags[0];
            4'b0111: condex = !flags[0];
            4'b1000: condex = flags[1] && !flags[2];
            4'b1001: condex = !flags[1] || flags[2];
            4'b1010: condex = (flags[3] == flags[0]);
            4'b1011: condex = (flags[3] != flags[0]);
            4'b1100: condex = !flags[2] && (flags[3] == flags[0]);
            4'b1101: condex = flags[2] || (flags[3] != flags[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign pcs      = (reg_w && Instr[15:12] == 4'b1111) || branch;
    assign PCWrite  = reset && (next_pc || (pcs && condexq));
    assign RegWrite = reset && reg_w && condexq;
    assign MemWrite = reset && mem_w && condexq;
    assign IRWrite  = reset && ir_w;
    assign ImmSrc   = op;
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    assign State    = state;

endmodule
